// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory/peripheral bus.
// Handles req/ack handshakes, slave wait states and aborts stalled transfers with a watchdog.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        m0_req_i,
  input  logic        m0_write_i,
  input  logic [31:0] m0_address_i,
  input  logic [31:0] m0_write_data_i,
  output logic [31:0] m0_read_data_o,
  output logic        m0_ack_o,
  output logic        m0_error_o,

  input  logic        m1_req_i,
  input  logic        m1_write_i,
  input  logic [31:0] m1_address_i,
  input  logic [31:0] m1_write_data_i,
  output logic [31:0] m1_read_data_o,
  output logic        m1_ack_o,
  output logic        m1_error_o,

  output logic [31:0] bus_address_o,
  output logic [31:0] bus_write_data_o,
  input  logic [31:0] bus_read_data_i,
  output logic        bus_read_o,
  output logic        bus_write_o,
  input  logic        bus_ready_i,
  output logic        bus_owner_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam bit          TimeoutEn   = (TIMEOUT != 0);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;  // m0 wins the first contended arbitration
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    grant   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (m0_req_i || m1_req_i) begin
          grant   = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
          state_d = StBusy;
          owner_d = grant;
          last_d  = grant;
          wr_d    = grant ? m1_write_i      : m0_write_i;
          addr_d  = grant ? m1_address_i    : m0_address_i;
          wdata_d = grant ? m1_write_data_i : m0_write_data_i;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        // A ready arriving on the watchdog's last cycle still completes normally.
        if (bus_ready_i) begin
          state_d = StDone;
          rdata_d = wr_q ? '0 : bus_read_data_i;
          err_d   = 1'b0;
        end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
          state_d = StDone;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  logic busy, done;
  assign busy = (state_q == StBusy);
  assign done = (state_q == StDone);

  assign bus_address_o    = busy ? addr_q : '0;
  assign bus_write_data_o = busy ? wdata_q : '0;
  assign bus_read_o       = busy & ~wr_q;
  assign bus_write_o      = busy & wr_q;
  assign bus_owner_o      = owner_q;

  assign m0_ack_o       = done & ~owner_q;
  assign m0_error_o     = done & ~owner_q & err_q;
  assign m0_read_data_o = (done & ~owner_q) ? rdata_q : '0;
  assign m1_ack_o       = done & owner_q;
  assign m1_error_o     = done & owner_q & err_q;
  assign m1_read_data_o = (done & owner_q) ? rdata_q : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand sequences for reset and
// alternation, and randomized transactions against a transaction-level arbitration model.
module tb_bus_arbiter;

  localparam int unsigned Tmo = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data;
  logic [31:0] m0_rd, m1_rd;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] bus_address, bus_write_data, bus_read_data;
  logic        bus_read, bus_write, bus_ready, bus_owner;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  bit pending [2];

  bus_arbiter #(.TIMEOUT(Tmo)) dut (
    .clock           (clock),
    .reset           (reset),
    .m0_req_i        (m0_req),
    .m0_write_i      (m0_write),
    .m0_address_i    (m0_address),
    .m0_write_data_i (m0_write_data),
    .m0_read_data_o  (m0_rd),
    .m0_ack_o        (m0_ack),
    .m0_error_o      (m0_err),
    .m1_req_i        (m1_req),
    .m1_write_i      (m1_write),
    .m1_address_i    (m1_address),
    .m1_write_data_i (m1_write_data),
    .m1_read_data_o  (m1_rd),
    .m1_ack_o        (m1_ack),
    .m1_error_o      (m1_err),
    .bus_address_o   (bus_address),
    .bus_write_data_o(bus_write_data),
    .bus_read_data_i (bus_read_data),
    .bus_read_o      (bus_read),
    .bus_write_o     (bus_write),
    .bus_ready_i     (bus_ready),
    .bus_owner_o     (bus_owner)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic raise(input int m, input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_req = 1'b1; m0_write = wr; m0_address = a; m0_write_data = d;
    end else begin
      m1_req = 1'b1; m1_write = wr; m1_address = a; m1_write_data = d;
    end
    pending[m] = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; runs one transaction and checks its completion.
  task automatic run_txn(input int w, input logic [31:0] sdata, input bit eo, input bit ee,
                         input int eb, output int ack_cyc);
    int busy;
    bit got;
    logic ewr;
    logic [31:0] eaddr, ewdata;
    busy    = 0;
    got     = 1'b0;
    ack_cyc = -1;
    ewr     = eo ? m1_write : m0_write;
    eaddr   = eo ? m1_address : m0_address;
    ewdata  = eo ? m1_write_data : m0_write_data;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clock);
      if (m0_ack || m1_ack) begin
        got       = 1'b1;
        ack_cyc   = cyc;
        bus_ready = 1'b0;
        check("ack_owner", {31'b0, m1_ack}, {31'b0, eo});
        check("ack_both", {31'b0, m0_ack & m1_ack}, 32'd0);
        check("ack_latency", 32'(c), 32'(eb + 1));
        check("busy_cycles", 32'(busy), 32'(eb));
        check("error", {31'b0, eo ? m1_err : m0_err}, {31'b0, ee});
        check("other_error", {31'b0, eo ? m0_err : m1_err}, 32'd0);
        check("read_data", eo ? m1_rd : m0_rd, (ee || ewr) ? 32'd0 : sdata);
        check("other_read_data", eo ? m0_rd : m1_rd, 32'd0);
        check("strobes_in_done", {30'b0, bus_read, bus_write}, 32'd0);
        check("bus_owner", {31'b0, bus_owner}, {31'b0, eo});
        if (eo) m1_req = 1'b0; else m0_req = 1'b0;
        pending[eo] = 1'b0;
      end else if (bus_read || bus_write) begin
        busy++;
        if (busy == 1) begin
          check("bus_address", bus_address, eaddr);
          check("bus_write_data", bus_write_data, ewdata);
          check("bus_strobes", {30'b0, bus_read, bus_write}, {30'b0, ~ewr, ewr});
          check("busy_owner", {31'b0, bus_owner}, {31'b0, eo});
        end
        bus_read_data = sdata;
        bus_ready     = (busy == w + 1);
      end
    end
    if (!got) begin
      vecs++;
      errs++;
      $display("FAIL ack_wait: no ack within 40 cycles, expected ack from m%0d", eo);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; bus_ready = 1'b0;
    pending[0] = 1'b0; pending[1] = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    bit          r0, r1;
    bit          wr;
    logic [31:0] addr, wdata;
    int          w;
    logic [31:0] sdata;
    bit          eo, ee;
    int          eb;
  } vec_t;

  vec_t tbl [7];
  int   ackc [7];

  initial begin
    int  ac;
    bit  last;
    bit  win;
    int  w;
    reset = 1'b1;
    {m0_req, m0_write, m1_req, m1_write, bus_ready} = '0;
    {m0_address, m0_write_data, m1_address, m1_write_data, bus_read_data} = '0;

    // Directed table; rows after the first run back to back from reset.
    tbl[0] = '{1, 1, 0, 32'h100,  32'h0,    0,   32'hDEADBEEF, 0, 0, 1};
    tbl[1] = '{0, 0, 0, 32'h0,    32'h0,    0,   32'h12345678, 1, 0, 1};
    tbl[2] = '{1, 0, 0, 32'h100,  32'h0,    0,   32'hDEADBEEF, 0, 0, 1};
    tbl[3] = '{0, 1, 1, 32'h2000, 32'h55AA, 4,   32'hFFFFFFFF, 1, 0, 5};
    tbl[4] = '{1, 0, 0, 32'h300,  32'h0,    100, 32'hCAFEF00D, 0, 1, 8};
    tbl[5] = '{1, 1, 0, 32'h400,  32'h0,    2,   32'hA5A5A5A5, 1, 0, 3};
    tbl[6] = '{0, 0, 0, 32'h0,    32'h0,    7,   32'h0BADC0DE, 0, 0, 8};

    repeat (2) @(negedge clock);
    check("rst_ack", {30'b0, m0_ack, m1_ack}, 32'd0);
    check("rst_err", {30'b0, m0_err, m1_err}, 32'd0);
    check("rst_strobes", {30'b0, bus_read, bus_write}, 32'd0);
    check("rst_owner", {31'b0, bus_owner}, 32'd0);
    check("rst_address", bus_address, 32'd0);
    check("rst_rdata", m0_rd | m1_rd, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].r0) raise(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].r1) raise(1, tbl[i].wr, ~tbl[i].addr, ~tbl[i].wdata);
      run_txn(tbl[i].w, tbl[i].sdata, tbl[i].eo, tbl[i].ee, tbl[i].eb, ackc[i]);
      @(negedge clock);
    end
    check("m1_after_m0_gap", 32'(ackc[1] - ackc[0]), 32'd3);

    // Continuous contention alternates owners starting with m0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (!pending[0]) raise(0, 1'b0, 32'h1000 + 32'(i), 32'h0);
      if (!pending[1]) raise(1, 1'b1, 32'h2000 + 32'(i), 32'h77 + 32'(i));
      run_txn(0, 32'h1111_0000 + 32'(i), bit'(i % 2), 1'b0, 1, ac);
      @(negedge clock);
    end

    // Asynchronous reset in the middle of a wait-stated read.
    do_reset();
    raise(0, 1'b1, 32'h0, 32'h0);
    raise(1, 1'b0, 32'h500, 32'h0);
    run_txn(0, 32'h0, 1'b0, 1'b0, 1, ac);  // m0 served, leaves last grant at m0
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    check("busy_before_reset", {31'b0, bus_read}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_strobe_drop", {30'b0, bus_read, bus_write}, 32'd0);
    check("async_no_ack", {28'b0, m0_ack, m1_ack, m0_err, m1_err}, 32'd0);
    m0_req = 1'b0; m1_req = 1'b0; pending[0] = 1'b0; pending[1] = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_idle", {28'b0, m0_ack, m1_ack, bus_read, bus_write}, 32'd0);
    raise(0, 1'b0, 32'h600, 32'h0);
    raise(1, 1'b0, 32'h700, 32'h0);
    run_txn(0, 32'h600D600D, 1'b0, 1'b0, 1, ac);
    @(negedge clock);
    run_txn(0, 32'h0000BEEF, 1'b1, 1'b0, 1, ac);
    @(negedge clock);

    // Random traffic against a transaction-level round-robin model.
    do_reset();
    last = 1'b1;
    for (int i = 0; i < 60; i++) begin
      for (int m = 0; m < 2; m++)
        if (!pending[m] && ($urandom_range(0, 1) == 1))
          raise(m, 1'($urandom), $urandom, $urandom);
      if (!pending[0] && !pending[1])
        raise($urandom_range(0, 1), 1'($urandom), $urandom, $urandom);
      win  = (pending[0] && pending[1]) ? !last : pending[1];
      last = win;
      w    = $urandom_range(0, 10);
      run_txn(w, $urandom, win, (w >= int'(Tmo)), (w >= int'(Tmo)) ? int'(Tmo) : w + 1, ac);
      @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
